// File: rtl/types.sv
// Shared video types for the chunk pipeline.
package types;
  typedef logic [7:0] pixel;
endpackage

// File: rtl/chunk_assembler_if.sv
// Pixel-stream input and chunk output bundle of the chunk assembler.
interface chunk_assembler_if #(
  parameter int unsigned CELL_SIZE  = 2,
  parameter int unsigned CHUNK_SIZE = 64
);
  types::pixel in_pixel;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  types::pixel [CELL_SIZE-1:0][CHUNK_SIZE-1:0][CELL_SIZE-1:0] video_chunk;
  logic        out_valid;
  logic        out_ready;
  logic        align_err;

  modport master (
    output in_pixel, in_valid, in_last, out_ready,
    input  in_ready, video_chunk, out_valid, align_err
  );

  modport slave (
    input  in_pixel, in_valid, in_last, out_ready,
    output in_ready, video_chunk, out_valid, align_err
  );
endinterface

// File: rtl/chunk_assembler.sv
// Collects CELL_SIZE raster rows into a ping-pong buffered chunk array
// with valid/ready output and in_last alignment checking.
module chunk_assembler #(
  parameter int unsigned CELL_SIZE  = 2,
  parameter int unsigned CHUNK_SIZE = 64
) (
  input logic              clk,
  input logic              rst,
  chunk_assembler_if.slave bus
);
  import types::*;

  localparam int unsigned PX_W   = (CELL_SIZE  > 1) ? $clog2(CELL_SIZE)  : 1;
  localparam int unsigned CELL_W = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam logic [PX_W-1:0]   PX_MAX   = PX_W'(CELL_SIZE - 1);
  localparam logic [CELL_W-1:0] CELL_MAX = CELL_W'(CHUNK_SIZE - 1);

  typedef pixel [CELL_SIZE-1:0][CHUNK_SIZE-1:0][CELL_SIZE-1:0] chunk_t;

  chunk_t            bank_q [2];
  chunk_t            bank_d [2];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  // The column counter is held as (cell, pixel-in-cell) so no divider is needed.
  logic [CELL_W-1:0] cell_q, cell_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [PX_W-1:0]   row_q, row_d;
  logic              align_err_q, align_err_d;

  logic accept;
  logic release_bank;
  logic at_end;

  assign bus.in_ready    = ~full_q[wr_bank_q];
  assign bus.out_valid   = full_q[rd_bank_q];
  assign bus.video_chunk = bank_q[rd_bank_q];
  assign bus.align_err   = align_err_q;

  assign accept       = bus.in_valid & ~full_q[wr_bank_q];
  assign release_bank = full_q[rd_bank_q] & bus.out_ready;
  assign at_end       = (row_q == PX_MAX) && (cell_q == CELL_MAX) && (px_q == PX_MAX);

  always_comb begin
    bank_d      = bank_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    cell_d      = cell_q;
    px_d        = px_q;
    row_d       = row_q;
    align_err_d = 1'b0;

    if (accept) begin
      bank_d[wr_bank_q][row_q][cell_q][px_q] = bus.in_pixel;
      if (at_end) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        cell_d            = '0;
        px_d              = '0;
        row_d             = '0;
        align_err_d       = ~bus.in_last;
      end else if (bus.in_last) begin
        // Early end: restart the same bank so the partial data is overwritten.
        cell_d      = '0;
        px_d        = '0;
        row_d       = '0;
        align_err_d = 1'b1;
      end else if (px_q == PX_MAX) begin
        px_d = '0;
        if (cell_q == CELL_MAX) begin
          cell_d = '0;
          row_d  = row_q + 1'b1;
        end else begin
          cell_d = cell_q + 1'b1;
        end
      end else begin
        px_d = px_q + 1'b1;
      end
    end

    // A released bank is always full, so it never collides with the write bank.
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]   <= '0;
      bank_q[1]   <= '0;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      cell_q      <= '0;
      px_q        <= '0;
      row_q       <= '0;
      align_err_q <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      cell_q      <= cell_d;
      px_q        <= px_d;
      row_q       <= row_d;
      align_err_q <= align_err_d;
    end
  end
endmodule

// File: tb/tb_chunk_assembler.sv
// Directed scoreboard bench for chunk_assembler at CELL_SIZE=2, CHUNK_SIZE=4.
module tb_chunk_assembler;
  import types::*;

  typedef pixel [1:0][3:0][1:0] chunk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chunk_assembler_if #(.CELL_SIZE(2), .CHUNK_SIZE(4)) bus ();

  chunk_assembler #(.CELL_SIZE(2), .CHUNK_SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  chunk_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     err_cnt  = 0;
  int     sent_cnt = 0;

  function automatic chunk_t exp_chunk(input int base);
    chunk_t ch;
    for (int unsigned r = 0; r < 2; r++)
      for (int unsigned c = 0; c < 4; c++)
        for (int unsigned p = 0; p < 2; p++)
          ch[r][c][p] = pixel'(base + int'(r * 8 + c * 2 + p));
    return ch;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit last);
    bit acc = 1'b0;
    bus.in_pixel = pixel'(v);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pixel %0d not accepted within 200 cycles", v);
    end else begin
      sent_cnt++;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected chunk.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.align_err) err_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL chunk_unexpected: got chunk with [0][0][0]=%0d expected no chunk",
                   bus.video_chunk[0][0][0]);
        end else begin
          chunk_t e;
          e = exp_q.pop_front();
          if (bus.video_chunk !== e) begin
            n_fail++;
            $display("FAIL chunk_data: got %h expected %h", bus.video_chunk, e);
          end
        end
      end
    end
  end

  initial begin
    int e0;
    chunk_t zero_c;
    zero_c = '0;
    bus.in_pixel  = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_align_err", int'(bus.align_err), 0);
    chk("rst_chunk_zero", int'(bus.video_chunk === zero_c), 1);
    rst = 1'b0;
    sync();

    // Basic chunk
    e0 = err_cnt;
    exp_q.push_back(exp_chunk(0));
    for (int i = 0; i < 16; i++) send(i, i == 15);
    idle();
    @(negedge clk);
    chk("basic_out_valid", int'(bus.out_valid), 1);
    chk("basic_011", int'(bus.video_chunk[0][1][1]), 3);
    chk("basic_100", int'(bus.video_chunk[1][0][0]), 8);
    chk("basic_131", int'(bus.video_chunk[1][3][1]), 15);
    @(negedge clk);
    chk("basic_valid_drop", int'(bus.out_valid), 0);
    chk("basic_no_err", err_cnt - e0, 0);
    sync();

    // Backpressure: three chunks with out_ready low
    e0 = err_cnt;
    sent_cnt = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 48; i++) begin
          if (i % 16 == 0) exp_q.push_back(exp_chunk(i));
          send(i, i % 16 == 15);
        end
        idle();
      end
      begin
        for (int n = 0; n < 400 && sent_cnt < 32; n++) @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", int'(bus.in_ready), 0);
        chk("bp_out_valid", int'(bus.out_valid), 1);
        chk("bp_first_000", int'(bus.video_chunk[0][0][0]), 0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_hold_stable", int'(bus.video_chunk === exp_chunk(0)), 1);
          chk("bp_stall_count", sent_cnt, 32);
        end
        sync();
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_all_sent", sent_cnt, 48);
    chk("bp_no_err", err_cnt - e0, 0);
    sync();

    // Early in_last
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) send(50 + i, i == 5);
    idle();
    @(negedge clk);
    chk("early_err_pulse", int'(bus.align_err), 1);
    chk("early_no_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("early_err_clear", int'(bus.align_err), 0);
    sync();
    exp_q.push_back(exp_chunk(100));
    for (int i = 0; i < 16; i++) send(100 + i, i == 15);
    idle();
    drain("early_drain");
    chk("early_err_count", err_cnt - e0, 1);
    sync();

    // Missing in_last
    e0 = err_cnt;
    exp_q.push_back(exp_chunk(200));
    for (int i = 0; i < 16; i++) send(200 + i, 1'b0);
    idle();
    @(negedge clk);
    chk("miss_err_pulse", int'(bus.align_err), 1);
    chk("miss_out_valid", int'(bus.out_valid), 1);
    @(negedge clk);
    chk("miss_err_clear", int'(bus.align_err), 0);
    drain("miss_drain");
    chk("miss_err_count", err_cnt - e0, 1);
    sync();

    // Release of one bank and completion of the other on the same edge
    bus.out_ready = 1'b0;
    exp_q.push_back(exp_chunk(120));
    for (int i = 0; i < 16; i++) send(120 + i, i == 15);
    exp_q.push_back(exp_chunk(140));
    for (int i = 0; i < 15; i++) send(140 + i, 1'b0);
    bus.out_ready = 1'b1;
    send(155, 1'b1);
    idle();
    @(negedge clk);
    chk("simul_out_valid", int'(bus.out_valid), 1);
    chk("simul_000", int'(bus.video_chunk[0][0][0]), 140);
    chk("simul_131", int'(bus.video_chunk[1][3][1]), 155);
    drain("simul_drain");
    sync();

    // Reset mid-chunk
    for (int i = 0; i < 7; i++) send(160 + i, 1'b0);
    idle();
    rst = 1'b1;
    #2;
    chk("mrst_out_valid", int'(bus.out_valid), 0);
    chk("mrst_in_ready", int'(bus.in_ready), 1);
    chk("mrst_chunk_zero", int'(bus.video_chunk === zero_c), 1);
    chk("mrst_align_err", int'(bus.align_err), 0);
    @(negedge clk);
    rst = 1'b0;
    sync();
    exp_q.push_back(exp_chunk(170));
    for (int i = 0; i < 16; i++) send(170 + i, i == 15);
    idle();
    drain("mrst_drain");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
